// File: rtl/vedic_mul_pipe.sv
// Pipelined Urdhva-Tiryakbhyam multiplier: sign/magnitude front end, Vedic core built from 2x2
// cells, and a valid/ready handshake where a stall freezes every stage.
module vedic_mul_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PIPE  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               sgn_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned HP = (H < 2) ? 2 : H;  // core width, at least one 2x2 cell
  localparam int unsigned ND = HP / 2;
  localparam int unsigned PW = 2 * WIDTH;

  function automatic logic [3:0] cell2(input logic [1:0] x, input logic [1:0] y);
    logic       c1;
    logic [3:0] r;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c1   = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c1;
    r[3] = (x[1] & y[1]) & c1;
    return r;
  endfunction

  // Bottom-up form of the recursion: all digit-pair products at one block size feed the next.
  function automatic logic [2*HP-1:0] vmul(input logic [HP-1:0] x, input logic [HP-1:0] y);
    logic [2*HP-1:0] cur [ND][ND];
    logic [2*HP-1:0] nxt [ND][ND];
    for (int unsigned i = 0; i < ND; i++) begin
      for (int unsigned j = 0; j < ND; j++) begin
        cur[i][j]      = '0;
        cur[i][j][3:0] = cell2(x[2*i +: 2], y[2*j +: 2]);
      end
    end
    for (int unsigned n = 4; n <= HP; n = n * 2) begin
      nxt = cur;
      for (int unsigned i = 0; i < HP / n; i++) begin
        for (int unsigned j = 0; j < HP / n; j++) begin
          nxt[i][j] = cur[2*i][2*j]
                    + ((cur[2*i+1][2*j] + cur[2*i][2*j+1]) << (n / 2))
                    + (cur[2*i+1][2*j+1] << n);
        end
      end
      cur = nxt;
    end
    return cur[0][0];
  endfunction

  logic                   stall;
  logic [WIDTH-1:0]       am_c, bm_c;
  logic                   neg_c;
  logic [WIDTH-1:0]       am_s, bm_s;
  logic                   neg_s, v_s;
  logic [3:0][2*H-1:0]    pp_c, pp_m;
  logic                   neg_m, v_m;
  logic [2*HP-1:0]        t_ll, t_hl, t_lh, t_hh;
  logic [PW-1:0]          pu, p_c;
  logic                   ov_q;
  logic [PW-1:0]          p_q;

  assign stall       = ov_q & ~out_ready_i;
  assign in_ready_o  = ~stall;
  assign out_valid_o = ov_q;
  assign p_o         = p_q;

  always_comb begin
    am_c  = (sgn_i & a_i[WIDTH-1]) ? -a_i : a_i;
    bm_c  = (sgn_i & b_i[WIDTH-1]) ? -b_i : b_i;
    neg_c = sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
  end

  if (PIPE >= 2) begin : g_s1
    logic [WIDTH-1:0] am_q, bm_q;
    logic             neg1_q, v1_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q   <= 1'b0;
        am_q   <= '0;
        bm_q   <= '0;
        neg1_q <= 1'b0;
      end else if (!stall) begin
        v1_q <= in_valid_i;
        if (in_valid_i) begin
          am_q   <= am_c;
          bm_q   <= bm_c;
          neg1_q <= neg_c;
        end
      end
    end
    assign am_s  = am_q;
    assign bm_s  = bm_q;
    assign neg_s = neg1_q;
    assign v_s   = v1_q;
  end else begin : g_no_s1
    assign am_s  = am_c;
    assign bm_s  = bm_c;
    assign neg_s = neg_c;
    assign v_s   = in_valid_i;
  end

  // pp index: 0 = lo*lo, 1 = a_hi*b_lo, 2 = a_lo*b_hi, 3 = hi*hi
  always_comb begin
    t_ll    = vmul(HP'(am_s[H-1:0]), HP'(bm_s[H-1:0]));
    t_hl    = vmul(HP'(am_s[WIDTH-1:H]), HP'(bm_s[H-1:0]));
    t_lh    = vmul(HP'(am_s[H-1:0]), HP'(bm_s[WIDTH-1:H]));
    t_hh    = vmul(HP'(am_s[WIDTH-1:H]), HP'(bm_s[WIDTH-1:H]));
    pp_c[0] = t_ll[2*H-1:0];
    pp_c[1] = t_hl[2*H-1:0];
    pp_c[2] = t_lh[2*H-1:0];
    pp_c[3] = t_hh[2*H-1:0];
  end

  if (PIPE >= 3) begin : g_s2
    logic [3:0][2*H-1:0] pp_q;
    logic                neg2_q, v2_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q   <= 1'b0;
        pp_q   <= '0;
        neg2_q <= 1'b0;
      end else if (!stall) begin
        v2_q <= v_s;
        if (v_s) begin
          pp_q   <= pp_c;
          neg2_q <= neg_s;
        end
      end
    end
    assign pp_m  = pp_q;
    assign neg_m = neg2_q;
    assign v_m   = v2_q;
  end else begin : g_no_s2
    assign pp_m  = pp_c;
    assign neg_m = neg_s;
    assign v_m   = v_s;
  end

  always_comb begin
    pu  = PW'(pp_m[0])
        + ((PW'(pp_m[1]) + PW'(pp_m[2])) << H)
        + (PW'(pp_m[3]) << WIDTH);
    p_c = neg_m ? -pu : pu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      p_q  <= '0;
    end else if (!stall) begin
      ov_q <= v_m;
      if (v_m) p_q <= p_c;
    end
  end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Bench for vedic_mul_pipe: 16-bit/3-stage main instance with scoreboard, plus 8-bit/1-stage
// (exhaustive unsigned) and 32-bit/2-stage instances.
module tb_vedic_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, sgn, out_valid, out_ready;
  logic [15:0] a, b;
  logic [31:0] p;

  logic        v8, rdy8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        v32, rdy32, s32, ov32, or32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  logic [31:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_p = '0;
  bit          done;

  vedic_mul_pipe #(.WIDTH(16), .PIPE(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready), .a_i(a), .b_i(b),
    .sgn_i(sgn), .out_valid_o(out_valid), .out_ready_i(out_ready), .p_o(p)
  );

  vedic_mul_pipe #(.WIDTH(8), .PIPE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v8), .in_ready_o(rdy8), .a_i(a8), .b_i(b8),
    .sgn_i(s8), .out_valid_o(ov8), .out_ready_i(or8), .p_o(p8)
  );

  vedic_mul_pipe #(.WIDTH(32), .PIPE(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v32), .in_ready_o(rdy32), .a_i(a32), .b_i(b32),
    .sgn_i(s32), .out_valid_o(ov32), .out_ready_i(or32), .p_o(p32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer multiply of the (optionally sign-extended) operands.
  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                          input bit s, input int w);
    logic [63:0] lo_mask, p_mask;
    lo_mask = (64'd1 << w) - 64'd1;
    p_mask  = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    x = x & lo_mask;
    y = y & lo_mask;
    if (s && x[w-1]) x = x | ~lo_mask;
    if (s && y[w-1]) y = y | ~lo_mask;
    return (x * y) & p_mask;
  endfunction

  // Scoreboard for the main instance; everything sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_p", p, prev_p);
        check_eq("hold_valid", out_valid, 1);
      end
      if (out_valid && !out_ready) check_eq("stall_in_ready", in_ready, 0);
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", out_valid, 0);
      end else if (out_valid && out_ready) begin
        check_eq("stream_p", p, exp_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) exp_q.push_back(32'(ref_mul(64'(a), 64'(b), sgn, 16)));
      prev_stall = out_valid && !out_ready;
      prev_p     = p;
    end
  end

  // Called at posedge+1 with in_valid low; returns at posedge+1 right after acceptance.
  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic s);
    int k;
    in_valid = 1'b1;
    a = x;
    b = y;
    sgn = s;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check_eq("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic corner(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic s, input logic [31:0] expv);
    int k;
    drive(x, y, s);
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq(tag, p, expv);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int lat, n0;
    logic [63:0] r;
    logic [31:0] c32 [4];
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
    v32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; or32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_p", p, 0);
    check_eq("rst_ov8", ov8, 0);
    check_eq("rst_ov32", ov32, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: latency and value
    drive(16'd1234, 16'd5678, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("t1_latency", lat, 3);
    check_eq("t1_p", p, 32'h006AE9BC);
    @(posedge clk);
    #1;

    // T2: corners
    corner("t2_ffff_u", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    corner("t2_m1_m1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    corner("t2_min_min", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    corner("t2_m3_5", 16'hFFFD, 16'd5, 1'b1, 32'hFFFFFFF1);
    corner("t2_zero", 16'h0000, 16'hBEEF, 1'b1, 32'h00000000);
    corner("t2_min_1", 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);

    // T3: 8 back-to-back; gap-free output means drained 3 cycles after last accept
    n0 = n_out;
    for (int i = 0; i < 8; i++) drive(16'($urandom), 16'($urandom), 1'($urandom));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("t3_drained", exp_q.size(), 0);
    check_eq("t3_count", n_out - n0, 8);
    @(posedge clk);
    #1;

    // T4: 5-cycle backpressure mid-stream
    n0 = n_out;
    fork
      for (int i = 0; i < 12; i++) drive(16'($urandom), 16'($urandom), 1'($urandom));
      begin
        repeat (4) @(posedge clk);
        #2;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain("t4_drained");
    check_eq("t4_count", n_out - n0, 12);

    // Random traffic with random backpressure
    n0 = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          drive(pick16(), pick16(), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("rnd_drained");
    check_eq("rnd_count", n_out - n0, 300);

    // T5: reset with 3 in flight
    for (int i = 0; i < 3; i++) drive(16'($urandom), 16'($urandom), 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t5_out_valid", out_valid, 0);
    check_eq("t5_p", p, 0);
    check_eq("t5_in_ready", in_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_eq("t5_no_stale", out_valid, 0);
    end
    n0 = n_out;
    drive(16'd300, 16'hFF00, 1'b1);
    drain("t5_after");
    check_eq("t5_after_count", n_out - n0, 1);

    // WIDTH=8, PIPE=1: exhaustive unsigned, then random signed
    for (int i = 0; i < 65536; i++) begin
      a8 = i[15:8];
      b8 = i[7:0];
      s8 = 1'b0;
      v8 = 1'b1;
      @(posedge clk);
      #1;
      r = ref_mul(64'(a8), 64'(b8), 1'b0, 8);
      check_eq("w8_u", {ov8, p8}, {1'b1, r[15:0]});
    end
    for (int i = 0; i < 400; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      s8 = 1'b1;
      v8 = 1'b1;
      @(posedge clk);
      #1;
      r = ref_mul(64'(a8), 64'(b8), 1'b1, 8);
      check_eq("w8_s", {ov8, p8}, {1'b1, r[15:0]});
    end
    v8 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("w8_idle", ov8, 0);

    // WIDTH=32, PIPE=2: corners then random
    c32[0] = 32'hFFFFFFFF;
    c32[1] = 32'h80000000;
    c32[2] = 32'h00000000;
    c32[3] = 32'hFFFFFFFD;
    for (int i = 0; i < 208; i++) begin
      if (i < 16) begin
        a32 = c32[i % 4];
        b32 = c32[(i / 4) % 4];
        s32 = 1'(i / 8);
      end else begin
        a32 = $urandom;
        b32 = $urandom;
        s32 = 1'($urandom);
      end
      v32 = 1'b1;
      @(posedge clk);
      #1;
      v32 = 1'b0;
      check_eq("w32_lat", ov32, 0);
      @(posedge clk);
      #1;
      check_eq("w32_valid", ov32, 1);
      check_eq("w32_p", p32, ref_mul(64'(a32), 64'(b32), s32, 32));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
